// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   slot_t     : one queue slot {pc, instr, filled}
//   RESET_PC   : PC value the fetch stream restarts from after reset
//   PERF_CNT_W : width of the optional performance counters (IFETCH_PERF_CNT_EN)
package ifetch_pkg;

  localparam logic [31:0] RESET_PC   = 32'd0;
  localparam int unsigned PERF_CNT_W = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } slot_t;

  localparam slot_t SLOT_RESET = '{pc: RESET_PC, instr: 32'd0, filled: 1'b0};

endpackage

// File: rtl/ifetch_queue_if.sv
// Bundle of the fetch stage's PC, instruction-memory and decode-side signals.
//   pc_in/pc_en/flush                     : PC register side
//   imem_req_* / imem_rsp_*               : instruction memory request/response
//   out_valid/out_instr/out_pc/out_ready  : decode side
// Modport master is the fetch queue; slave is its environment.
interface ifetch_queue_if;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        flush;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    input  pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output pc_en, imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  pc_en, imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/ifetch_perf.sv
// Fetch performance counters, only built when IFETCH_PERF_CNT_EN is defined.
//   clk, reset  : clock, synchronous active-high clear
//   fetch_i     : request accepted this cycle
//   stall_i     : request withheld this cycle (outside reset/flush)
//   drop_i      : response discarded this cycle
//   *_cnt_o     : free-running wrapping event counts
module ifetch_perf
  import ifetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_i,
  input  logic                  stall_i,
  input  logic                  drop_i,
  output logic [PERF_CNT_W-1:0] fetch_cnt_o,
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] drop_cnt_o
);

  logic [PERF_CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + PERF_CNT_W'(fetch_i);
    stall_cnt_d = stall_cnt_q + PERF_CNT_W'(stall_i);
    drop_cnt_d  = drop_cnt_q + PERF_CNT_W'(drop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues pc_in as a memory request, advances the PC only on an
// accepted request (or a redirect), pairs in-order responses with their PCs in a slot ring
// and hands them to decode. A flush empties the ring and remembers how many in-flight
// responses are now stale so they can be dropped on arrival.
//   clk, reset : clock, synchronous active-high reset (wins over everything)
//   bus        : ifetch_queue_if.master (PC, imem request/response, decode output)
//   perf_*_cnt : fetch/stall/drop counters, present only with IFETCH_PERF_CNT_EN defined
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  ifetch_queue_if.master        bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_fetch_cnt,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_drop_cnt
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  slot_t            slots_q [DEPTH];
  slot_t            slots_d [DEPTH];
  logic [PtrW-1:0]  alloc_q, alloc_d;
  logic [PtrW-1:0]  fill_q, fill_d;
  logic [PtrW-1:0]  head_q, head_d;
  logic [CntW-1:0]  used_q, used_d;
  logic [CntW-1:0]  drop_q, drop_d;

  logic [CntW-1:0]  filled_cnt;
  logic [CntW-1:0]  pend;
  logic [CntW:0]    occ;
  logic [CntW:0]    drop_sum;
  logic             room;
  logic             req_fire;
  logic             pop;

  // Allocated-but-unfilled slots are exactly the live requests still awaiting a response.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + CntW'(slots_q[i].filled);
    end
    pend = used_q - filled_cnt;
  end

  // Stale responses still reserve capacity, so a redirect cannot overrun the ring.
  assign occ  = {1'b0, used_q} + {1'b0, drop_q};
  assign room = occ < (CntW + 1)'(DEPTH);

  assign bus.imem_req_valid = !reset && !bus.flush && room;
  assign bus.imem_req_addr  = bus.pc_in;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign bus.pc_en          = !reset && (req_fire || bus.flush);

  assign bus.out_valid = !reset && !bus.flush && slots_q[head_q].filled;
  assign bus.out_pc    = slots_q[head_q].pc;
  assign bus.out_instr = slots_q[head_q].instr;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    slots_d  = slots_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    head_d   = head_q;
    used_d   = used_q;
    drop_d   = drop_q;
    drop_sum = '0;

    if (req_fire) begin
      slots_d[alloc_q] = '{pc: bus.pc_in, instr: 32'd0, filled: 1'b0};
      alloc_d          = alloc_q + PtrW'(1);
      used_d           = used_d + CntW'(1);
    end

    if (bus.imem_rsp_valid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - CntW'(1);
      end else if (pend != '0) begin
        slots_d[fill_q].instr  = bus.imem_rsp_data;
        slots_d[fill_q].filled = 1'b1;
        fill_d                 = fill_q + PtrW'(1);
      end
    end

    if (pop) begin
      slots_d[head_q].filled = 1'b0;
      head_d                 = head_q + PtrW'(1);
      used_d                 = used_d - CntW'(1);
    end

    if (bus.flush) begin
      slots_d  = '{default: SLOT_RESET};
      alloc_d  = '0;
      fill_d   = '0;
      head_d   = '0;
      used_d   = '0;
      // Everything still in flight becomes stale; a response landing now is already gone.
      drop_sum = {1'b0, drop_q} + {1'b0, pend};
      if (bus.imem_rsp_valid && (drop_sum != '0)) begin
        drop_sum = drop_sum - (CntW + 1)'(1);
      end
      drop_d   = drop_sum[CntW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slots_q <= '{default: SLOT_RESET};
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      used_q  <= '0;
      drop_q  <= '0;
    end else begin
      slots_q <= slots_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
      used_q  <= used_d;
      drop_q  <= drop_d;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic perf_stall;
  logic perf_drop;

  assign perf_stall = !reset && !bus.flush && !room;
  assign perf_drop  = !reset && bus.imem_rsp_valid && (bus.flush || (drop_q != '0));

  ifetch_perf u_perf (
    .clk         (clk),
    .reset       (reset),
    .fetch_i     (req_fire),
    .stall_i     (perf_stall),
    .drop_i      (perf_drop),
    .fetch_cnt_o (perf_fetch_cnt),
    .stall_cnt_o (perf_stall_cnt),
    .drop_cnt_o  (perf_drop_cnt)
  );
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue. The reference model tracks the fetch stream as
// queues of in-flight requests tagged with a redirect epoch; expected decode outputs go
// into a scoreboard that a separate monitor drains on every decode handshake.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    int          epoch;
    int          due;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mem_t mem_q[$];
  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int epoch    = 0;
  int live_cnt = 0;  // live fetches accepted and not yet consumed by decode
  int live_rsp = 0;  // live fetches whose instruction has arrived but is not consumed
  logic [31:0] pc_reg = RESET_PC;
  logic post_rst = 1'b0;
  int m_fetch = 0;
  int m_stall = 0;
  int m_drop  = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s cyc=%0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every decode handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check32("unexpected_pop", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check32("out_pc", bus.out_pc, e.pc);
        check32("out_instr", bus.out_instr, e.instr);
      end
    end
  end

  // One clock cycle: drive inputs, check combinational outputs, advance the model.
  task automatic step(input int p_ready, input int p_rsp, input int p_out, input int p_flush,
                      input bit do_reset);
    logic [31:0] r;
    logic [31:0] tgt;
    int   stale;
    logic e_req, e_fire, e_pc_en, e_out_valid;
    mem_t m;
    exp_t e;

    @(posedge clk);
    #1;
    cyc++;
    reset              = do_reset;
    bus.flush          = !do_reset && ($urandom_range(99) < p_flush);
    r                  = $urandom();
    tgt                = {r[31:2], 2'b00};
    bus.imem_req_ready = ($urandom_range(99) < p_ready);
    bus.out_ready      = ($urandom_range(99) < p_out);
    bus.pc_in          = pc_reg;
    if (!do_reset && mem_q.size() > 0 && mem_q[0].due <= cyc &&
        $urandom_range(99) < p_rsp) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(mem_q[0].pc);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom();
    end

    @(negedge clk);
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    e_req       = !reset && !bus.flush && ((live_cnt + stale) < DEPTH);
    e_fire      = e_req && bus.imem_req_ready;
    e_pc_en     = !reset && (e_fire || bus.flush);
    e_out_valid = !reset && !bus.flush && (live_rsp > 0);

    check32("imem_req_valid", 32'(bus.imem_req_valid), 32'(e_req));
    check32("pc_en", 32'(bus.pc_en), 32'(e_pc_en));
    check32("imem_req_addr", bus.imem_req_addr, pc_reg);
    check32("out_valid", 32'(bus.out_valid), 32'(e_out_valid));
    if (post_rst && !reset) begin
      check32("rst_out_pc", bus.out_pc, 32'd0);
      check32("rst_out_instr", bus.out_instr, 32'd0);
    end
    post_rst = reset;

    if (reset) begin
      mem_q.delete();
      sb_q.delete();
      live_cnt = 0;
      live_rsp = 0;
      pc_reg   = RESET_PC;
      m_fetch  = 0;
      m_stall  = 0;
      m_drop   = 0;
    end else begin
      if (!e_req && !bus.flush) m_stall++;
      if (e_out_valid && bus.out_ready) begin
        live_cnt--;
        live_rsp--;
      end
      if (bus.imem_rsp_valid) begin
        m = mem_q.pop_front();
        if (!bus.flush && m.epoch == epoch) live_rsp++;
        else m_drop++;
      end
      if (e_fire) begin
        m.pc    = pc_reg;
        m.epoch = epoch;
        m.due   = cyc + 1;
        mem_q.push_back(m);
        e.pc    = pc_reg;
        e.instr = instr_of(pc_reg);
        sb_q.push_back(e);
        live_cnt++;
        m_fetch++;
      end
      if (bus.flush) begin
        epoch++;
        live_cnt = 0;
        live_rsp = 0;
        sb_q.delete();
      end
      if (e_pc_en) pc_reg = bus.flush ? tgt : pc_reg + 32'd4;
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.flush          = 1'b0;
    bus.pc_in          = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.out_ready      = 1'b0;

    repeat (2) step(0, 0, 0, 0, 1'b1);
    // Zero-wait memory, decode always ready.
    repeat (12) step(100, 100, 100, 0, 1'b0);
    // Decode stalls: queue fills and the PC must hold, then drain.
    repeat (6) step(100, 100, 0, 0, 1'b0);
    step(100, 100, 100, 0, 1'b0);
    repeat (4) step(100, 100, 0, 0, 1'b0);
    repeat (4) step(100, 100, 100, 0, 1'b0);
    // Two responses outstanding, then a redirect.
    repeat (3) step(100, 0, 100, 0, 1'b0);
    step(100, 0, 100, 100, 1'b0);
    repeat (8) step(100, 100, 100, 0, 1'b0);
    // Redirect coinciding with a response.
    repeat (3) step(100, 0, 100, 0, 1'b0);
    step(100, 100, 100, 100, 1'b0);
    repeat (8) step(100, 100, 100, 0, 1'b0);
    // Reset mid-stream with a full queue.
    repeat (5) step(100, 100, 0, 0, 1'b0);
    step(100, 100, 0, 0, 1'b1);
    repeat (8) step(100, 100, 100, 0, 1'b0);
    // Random traffic with occasional redirects and rare resets.
    for (int i = 0; i < 4000; i++) begin
      step(70, 60, 70, 6, ($urandom_range(499) == 0));
    end
    repeat (6) step(100, 100, 100, 0, 1'b0);

`ifdef IFETCH_PERF_CNT_EN
    @(posedge clk);
    #1;
    check32("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
    check32("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
    check32("perf_drop_cnt", perf_drop_cnt, 32'(m_drop));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
